param_dual_port_ram: RTL and testbench

- Parametrised true dual-port synchronous RAM. Next generation of the team's fixed 8-bit by 64-word single/dual-port RAMs.
- Adds configurable width and depth, per-port enables, a selectable read-during-write mode, registered read-valid flags, cross-port collision detection, and a hardware clear engine.
- Used as the general scratch and buffer memory for datapath blocks that currently instantiate the fixed RAMs.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_clear_fsm.sv | 70 +++++++
 rtl/param_dual_port_ram.sv | 115 +++++++++++
 tb/tb_param_dual_port_ram.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and FSM encoding for param_dual_port_ram
package ram_pkg;

    // Same-port read-during-write behaviour selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Clear engine states
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - sweeps INIT_VALUE through the array after reset or on request
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - request a fresh sweep from address 0
//   busy        - high while the sweep owns the array
//   clr_we      - write strobe for the sweep
//   clr_addr    - address being cleared this cycle
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    // One extra bit on the pointer keeps the terminal compare unambiguous
    localparam logic [ADDR_WIDTH:0] LAST_PTR = {1'b0, {ADDR_WIDTH{1'b1}}};

    ram_state_t            state, state_next;
    logic [ADDR_WIDTH:0]   ptr, ptr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we     = 1'b0;
        clr_addr   = ptr[ADDR_WIDTH-1:0];
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clear) begin
                    ptr_next = '0;
                end else if (ptr == LAST_PTR) begin
                    state_next = ST_READY;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + (ADDR_WIDTH+1)'(1);
                end
            end
            ST_READY: begin
                if (clear) begin
                    state_next = ST_CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/param_dual_port_ram.sv
// rtl/param_dual_port_ram.sv - parametrised true dual-port RAM with clear engine
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   clear / busy                - re-clear request / clear engine owns the array
//   a_en, a_write_enable        - port A enable and write select
//   a_addr, a_data              - port A address and write data
//   a_read, a_valid             - port A registered read data and update flag
//   b_*                         - same set for port B
//   collision                   - one-cycle flag for a same-address access with a write
module param_dual_port_ram
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  a_en,
    input  logic                  a_write_enable,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic [DATA_WIDTH-1:0] a_read,
    output logic                  a_valid,
    input  logic                  b_en,
    input  logic                  b_write_enable,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] b_read,
    output logic                  b_valid,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Qualified user accesses: nothing gets through while the sweep runs
    logic a_rd, a_wr, b_rd, b_wr, same_addr, conflict;
    assign a_rd      = !busy && a_en && !a_write_enable;
    assign a_wr      = !busy && a_en &&  a_write_enable;
    assign b_rd      = !busy && b_en && !b_write_enable;
    assign b_wr      = !busy && b_en &&  b_write_enable;
    assign same_addr = (a_addr == b_addr);
    assign conflict  = (a_rd || a_wr) && (b_rd || b_wr) && same_addr && (a_wr || b_wr);

    // The clear engine borrows port A's write path
    logic                  wa_en;
    logic [ADDR_WIDTH-1:0] wa_addr;
    logic [DATA_WIDTH-1:0] wa_data;
    assign wa_en   = clr_we || a_wr;
    assign wa_addr = clr_we ? clr_addr   : a_addr;
    assign wa_data = clr_we ? INIT_VALUE : a_data;

    // Word port B sees as "new" in write-first mode: A wins a double write
    logic [DATA_WIDTH-1:0] b_new;
    assign b_new = (a_wr && same_addr) ? a_data : b_data;

    // Port A is written after port B so it takes priority on a shared address
    always_ff @(posedge clk) begin
        if (b_wr) begin
            mem[b_addr] <= b_data;
        end
        if (wa_en) begin
            mem[wa_addr] <= wa_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_read    <= '0;
            a_valid   <= 1'b0;
            b_read    <= '0;
            b_valid   <= 1'b0;
            collision <= 1'b0;
        end else begin
            collision <= conflict;

            a_valid <= 1'b0;
            if (a_rd) begin
                a_read  <= mem[a_addr];
                a_valid <= 1'b1;
            end else if (a_wr && RDW_MODE != RDW_NO_CHANGE) begin
                a_read  <= (RDW_MODE == RDW_WRITE_FIRST) ? a_data : mem[a_addr];
                a_valid <= 1'b1;
            end

            b_valid <= 1'b0;
            if (b_rd) begin
                b_read  <= mem[b_addr];
                b_valid <= 1'b1;
            end else if (b_wr && RDW_MODE != RDW_NO_CHANGE) begin
                b_read  <= (RDW_MODE == RDW_WRITE_FIRST) ? b_new : mem[b_addr];
                b_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_dual_port_ram.sv
// tb/tb_param_dual_port_ram.sv - checks all three read-during-write modes against a reference model
module tb_param_dual_port_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [5:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;

    logic       busy_o [3];
    logic [7:0] a_read_o [3];
    logic [7:0] b_read_o [3];
    logic       a_valid_o [3];
    logic       b_valid_o [3];
    logic       coll_o [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        param_dual_port_ram #(
            .DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(g), .INIT_VALUE(8'h00)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .clear          (clear),
            .busy           (busy_o[g]),
            .a_en           (a_en),
            .a_write_enable (a_we),
            .a_addr         (a_addr),
            .a_data         (a_data),
            .a_read         (a_read_o[g]),
            .a_valid        (a_valid_o[g]),
            .b_en           (b_en),
            .b_write_enable (b_we),
            .b_addr         (b_addr),
            .b_data         (b_data),
            .b_read         (b_read_o[g]),
            .b_valid        (b_valid_o[g]),
            .collision      (coll_o[g])
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: array contents, remaining sweep cycles, expected outputs per mode
    logic [7:0] mdl_mem [64];
    int         busy_left = 64;
    logic [7:0] exp_ar [3];
    logic [7:0] exp_br [3];
    logic       exp_av [3];
    logic       exp_bv [3];
    logic       exp_col = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_left = 64;
        exp_col   = 1'b0;
        for (int m = 0; m < 3; m++) begin
            exp_ar[m] = 8'h00; exp_br[m] = 8'h00;
            exp_av[m] = 1'b0;  exp_bv[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] old_a, old_b;
        logic       a_w, b_w;
        if (busy_left > 0) begin
            exp_col = 1'b0;
            for (int m = 0; m < 3; m++) begin
                exp_av[m] = 1'b0; exp_bv[m] = 1'b0;
            end
            if (clear) begin
                busy_left = 64;
            end else begin
                busy_left--;
                if (busy_left == 0)
                    for (int i = 0; i < 64; i++) mdl_mem[i] = 8'h00;
            end
        end else begin
            old_a   = mdl_mem[a_addr];
            old_b   = mdl_mem[b_addr];
            a_w     = a_en && a_we;
            b_w     = b_en && b_we;
            exp_col = a_en && b_en && (a_addr == b_addr) && (a_we || b_we);
            for (int m = 0; m < 3; m++) begin
                exp_av[m] = 1'b0;
                if (a_en && !a_we) begin
                    exp_ar[m] = old_a; exp_av[m] = 1'b1;
                end else if (a_w && m != 2) begin
                    exp_ar[m] = (m == 1) ? a_data : old_a; exp_av[m] = 1'b1;
                end
                exp_bv[m] = 1'b0;
                if (b_en && !b_we) begin
                    exp_br[m] = old_b; exp_bv[m] = 1'b1;
                end else if (b_w && m != 2) begin
                    if (m == 0)                          exp_br[m] = old_b;
                    else if (a_w && a_addr == b_addr)    exp_br[m] = a_data;
                    else                                 exp_br[m] = b_data;
                    exp_bv[m] = 1'b1;
                end
            end
            if (b_w) mdl_mem[b_addr] = b_data;
            if (a_w) mdl_mem[a_addr] = a_data;
            if (clear) busy_left = 64;
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("m%0d busy", m),      busy_o[m],    (busy_left > 0));
            chk($sformatf("m%0d a_read", m),    a_read_o[m],  exp_ar[m]);
            chk($sformatf("m%0d a_valid", m),   a_valid_o[m], exp_av[m]);
            chk($sformatf("m%0d b_read", m),    b_read_o[m],  exp_br[m]);
            chk($sformatf("m%0d b_valid", m),   b_valid_o[m], exp_bv[m]);
            chk($sformatf("m%0d collision", m), coll_o[m],    exp_col);
        end
    endtask

    task automatic step(input logic ae, input logic awe, input logic [5:0] aa, input logic [7:0] ad,
                        input logic be, input logic bwe, input logic [5:0] ba, input logic [7:0] bd,
                        input logic clr);
        a_en = ae; a_we = awe; a_addr = aa; a_data = ad;
        b_en = be; b_we = bwe; b_addr = ba; b_data = bd;
        clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 0);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Power-up sweep: busy for exactly 64 edges
        idle(63);
        chk("busy before last sweep edge", busy_o[0], 1'b1);
        idle(1);
        chk("busy after sweep", busy_o[0], 1'b0);

        step(1, 0, 6'h05, 8'h00, 0, 0, 6'h00, 8'h00, 0);
        chk("read 05 after clear", a_read_o[0], 8'h00);
        chk("read 05 valid", a_valid_o[0], 1'b1);

        // Independent writes, then cross reads
        step(1, 1, 6'h01, 8'h33, 1, 1, 6'h02, 8'h44, 0);
        step(1, 0, 6'h02, 8'h00, 1, 0, 6'h01, 8'h00, 0);
        chk("cross read a", a_read_o[0], 8'h44);
        chk("cross read b", b_read_o[0], 8'h33);
        chk("cross no collision", coll_o[0], 1'b0);

        // Double write to one address: A wins
        step(1, 1, 6'h06, 8'hBB, 1, 1, 6'h06, 8'hCC, 0);
        chk("double write collision", coll_o[0], 1'b1);
        chk("write-first b sees a data", b_read_o[1], 8'hBB);
        step(1, 0, 6'h06, 8'h00, 1, 0, 6'h06, 8'h00, 0);
        chk("collision one cycle", coll_o[0], 1'b0);
        chk("a wins read a", a_read_o[0], 8'hBB);
        chk("a wins read b", b_read_o[0], 8'hBB);

        // Read-during-write in each mode
        step(1, 1, 6'h03, 8'hAA, 0, 0, 6'h00, 8'h00, 0);
        step(1, 1, 6'h03, 8'h55, 0, 0, 6'h00, 8'h00, 0);
        chk("read-first old word", a_read_o[0], 8'hAA);
        chk("write-first new word", a_read_o[1], 8'h55);
        chk("no-change valid low", a_valid_o[2], 1'b0);
        chk("no-change holds", a_read_o[2], 8'hBB);

        // Write while reading the same address from the other port
        step(1, 1, 6'h07, 8'h12, 1, 0, 6'h07, 8'h00, 0);

        // Clear pulse: writes during busy are dropped
        step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 1);
        chk("busy after clear", busy_o[0], 1'b1);
        step(1, 1, 6'h04, 8'h77, 0, 0, 6'h00, 8'h00, 0);
        idle(63);
        chk("busy after re-clear", busy_o[0], 1'b0);
        step(1, 0, 6'h04, 8'h00, 0, 0, 6'h00, 8'h00, 0);
        chk("write during busy ignored", a_read_o[0], 8'h00);

        // Reset in the middle of a sweep
        step(0, 0, 6'h00, 8'h00, 0, 0, 6'h00, 8'h00, 1);
        idle(20);
        reset_now();
        idle(63);
        chk("busy before restarted sweep ends", busy_o[0], 1'b1);
        idle(1);
        chk("busy after restarted sweep", busy_o[0], 1'b0);

        // Randomised traffic on a narrow address window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 6'($urandom_range(7, 0)), 8'($urandom),
                 1'($urandom), 1'($urandom), 6'($urandom_range(7, 0)), 8'($urandom),
                 ($urandom_range(99, 0) < 2));
        end

        // Reset during normal operation, then finish the sweep
        reset_now();
        idle(64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
